// File: rtl/pc_inc_reg_if.sv
// Request/response bundle between the sequencer and the program-counter block.
// Inputs come from the sequencer. Outputs go to the memory address bus.
interface pc_inc_reg_if;
    logic       addressLow_EN;
    logic       addressHigh_EN;
    logic [7:0] addressLowBus_IN;
    logic [7:0] addressHighBus_IN;
    logic       inc_EN;
    logic       branch_EN;
    logic [7:0] branchOffset_IN;
    logic [7:0] dataBus_IN;
    logic [7:0] addressLow_OUT;
    logic [7:0] addressHigh_OUT;
    logic [7:0] pcLow_OUT;
    logic [7:0] pcHigh_OUT;
    logic       ready_OUT;
    logic       vectorActive_OUT;

    modport master (
        output addressLow_EN, addressHigh_EN, addressLowBus_IN, addressHighBus_IN,
               inc_EN, branch_EN, branchOffset_IN, dataBus_IN,
        input  addressLow_OUT, addressHigh_OUT, pcLow_OUT, pcHigh_OUT,
               ready_OUT, vectorActive_OUT
    );

    modport slave (
        input  addressLow_EN, addressHigh_EN, addressLowBus_IN, addressHighBus_IN,
               inc_EN, branch_EN, branchOffset_IN, dataBus_IN,
        output addressLow_OUT, addressHigh_OUT, pcLow_OUT, pcHigh_OUT,
               ready_OUT, vectorActive_OUT
    );
endinterface

// File: rtl/pc_inc_reg.sv
// 16-bit program counter. It fetches its reset vector from FFFC/FFFD and supports
// load, increment and relative branch. A page-crossing branch costs one extra fix-up cycle.
module pc_inc_reg (
    input  logic          clk,
    input  logic          rst,
    pc_inc_reg_if.slave   bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PC_W   = 16;

    typedef enum logic [1:0] {VEC_LO, VEC_HI, RUN, FIXUP} state_t;

    state_t              state, state_nx;
    logic [BYTE_W-1:0]   pcl, pcl_nx;
    logic [BYTE_W-1:0]   pch, pch_nx;
    logic                dir_neg, dir_neg_nx;

    logic [BYTE_W-1:0]   addr_lo_c, addr_hi_c;
    logic [BYTE_W-1:0]   sel_lo, sel_hi;
    logic [BYTE_W:0]     br_sum;
    logic [PC_W-1:0]     pc_sum;
    logic                any_load, inc_eff, br_cross;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= VEC_LO;
            pcl     <= '0;
            pch     <= '0;
            dir_neg <= 1'b0;
        end else begin
            state   <= state_nx;
            pcl     <= pcl_nx;
            pch     <= pch_nx;
            dir_neg <= dir_neg_nx;
        end
    end

    // Datapath terms for RUN; a load on either byte overrides a branch.
    always_comb begin
        any_load = bus.addressLow_EN | bus.addressHigh_EN;
        sel_lo   = bus.addressLow_EN  ? bus.addressLowBus_IN  : pcl;
        sel_hi   = bus.addressHigh_EN ? bus.addressHighBus_IN : pch;
        inc_eff  = bus.inc_EN & ~bus.branch_EN;
        pc_sum   = {sel_hi, sel_lo} + PC_W'(inc_eff);
        br_sum   = {1'b0, pcl} + {1'b0, bus.branchOffset_IN};
        br_cross = bus.branchOffset_IN[BYTE_W-1] ? ~br_sum[BYTE_W] : br_sum[BYTE_W];
    end

    always_comb begin
        state_nx   = state;
        pcl_nx     = pcl;
        pch_nx     = pch;
        dir_neg_nx = dir_neg;
        addr_lo_c  = pcl;
        addr_hi_c  = pch;
        case (state)
            VEC_LO: begin
                addr_hi_c = 8'hFF;
                addr_lo_c = 8'hFC;
                pcl_nx    = bus.dataBus_IN;
                state_nx  = VEC_HI;
            end
            VEC_HI: begin
                addr_hi_c = 8'hFF;
                addr_lo_c = 8'hFD;
                pch_nx    = bus.dataBus_IN;
                state_nx  = RUN;
            end
            RUN: begin
                if (bus.branch_EN && !any_load) begin
                    pcl_nx = br_sum[BYTE_W-1:0];
                    if (br_cross) begin
                        dir_neg_nx = bus.branchOffset_IN[BYTE_W-1];
                        state_nx   = FIXUP;
                    end
                end else begin
                    pch_nx = pc_sum[PC_W-1:BYTE_W];
                    pcl_nx = pc_sum[BYTE_W-1:0];
                end
            end
            FIXUP: begin
                pch_nx   = dir_neg ? pch - 8'd1 : pch + 8'd1;
                state_nx = RUN;
            end
            default: state_nx = VEC_LO;
        endcase
    end

    assign bus.addressLow_OUT   = addr_lo_c;
    assign bus.addressHigh_OUT  = addr_hi_c;
    assign bus.pcLow_OUT        = pcl;
    assign bus.pcHigh_OUT       = pch;
    assign bus.ready_OUT        = (state == RUN);
    assign bus.vectorActive_OUT = (state == VEC_LO) || (state == VEC_HI);
endmodule

// File: tb/tb_pc_inc_reg.sv
// Randomized bench for pc_inc_reg. It checks against a 16-bit arithmetic model of the PC.
module tb_pc_inc_reg;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_inc_reg_if bus ();
    pc_inc_reg dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_pc;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.addressLow_EN     = 1'b0;
        bus.addressHigh_EN    = 1'b0;
        bus.addressLowBus_IN  = 8'h00;
        bus.addressHighBus_IN = 8'h00;
        bus.inc_EN            = 1'b0;
        bus.branch_EN         = 1'b0;
        bus.branchOffset_IN   = 8'h00;
        bus.dataBus_IN        = 8'h00;
    endtask

    task automatic rand_requests();
        bus.addressLow_EN     = 1'($urandom);
        bus.addressHigh_EN    = 1'($urandom);
        bus.addressLowBus_IN  = 8'($urandom);
        bus.addressHighBus_IN = 8'($urandom);
        bus.inc_EN            = 1'($urandom);
        bus.branch_EN         = 1'($urandom);
        bus.branchOffset_IN   = 8'($urandom);
    endtask

    function automatic logic [15:0] pc_now();
        return {bus.pcHigh_OUT, bus.pcLow_OUT};
    endfunction

    function automatic logic [15:0] addr_now();
        return {bus.addressHigh_OUT, bus.addressLow_OUT};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"},  addr_now(), 16'hFFFC);
        check_eq({tag, "_pc"},    pc_now(),   16'h0000);
        check_eq({tag, "_ready"}, 16'(bus.ready_OUT), 16'h0);
        check_eq({tag, "_vec"},   16'(bus.vectorActive_OUT), 16'h1);
    endtask

    // Vector fetch with random request noise, which must have no effect.
    task automatic do_vector(input logic [7:0] lo, input logic [7:0] hi);
        rand_requests();
        bus.dataBus_IN = lo;
        check_eq("vec_lo_addr", addr_now(), 16'hFFFC);
        check_eq("vec_lo_vec",  16'(bus.vectorActive_OUT), 16'h1);
        check_eq("vec_lo_ready", 16'(bus.ready_OUT), 16'h0);
        tick();
        rand_requests();
        bus.dataBus_IN = hi;
        check_eq("vec_hi_addr", addr_now(), 16'hFFFD);
        check_eq("vec_hi_vec",  16'(bus.vectorActive_OUT), 16'h1);
        tick();
        idle_inputs();
        m_pc = {hi, lo};
        check_eq("vec_pc",    pc_now(),   m_pc);
        check_eq("vec_addr",  addr_now(), m_pc);
        check_eq("vec_ready", 16'(bus.ready_OUT), 16'h1);
        check_eq("vec_vec",   16'(bus.vectorActive_OUT), 16'h0);
    endtask

    // One RUN-cycle request. The model computes the branch target as a 16-bit signed add.
    // A page cross is any change in the high byte.
    task automatic run_op(input string tag, input logic lo_en, input logic hi_en,
                          input logic [7:0] lo_bus, input logic [7:0] hi_bus,
                          input logic inc, input logic br, input logic [7:0] off);
        logic [15:0] tgt, mid;
        logic        fix;
        fix = 1'b0;
        if (br && !lo_en && !hi_en) begin
            tgt = m_pc + {{8{off[7]}}, off};
            if (tgt[15:8] != m_pc[15:8]) fix = 1'b1;
            mid = {m_pc[15:8], tgt[7:0]};
        end else begin
            tgt = {hi_en ? hi_bus : m_pc[15:8], lo_en ? lo_bus : m_pc[7:0]} + ((inc && !br) ? 16'd1 : 16'd0);
            mid = tgt;
        end
        bus.addressLow_EN     = lo_en;
        bus.addressHigh_EN    = hi_en;
        bus.addressLowBus_IN  = lo_bus;
        bus.addressHighBus_IN = hi_bus;
        bus.inc_EN            = inc;
        bus.branch_EN         = br;
        bus.branchOffset_IN   = off;
        tick();
        check_eq({tag, "_pc"},    pc_now(),   mid);
        check_eq({tag, "_addr"},  addr_now(), mid);
        check_eq({tag, "_ready"}, 16'(bus.ready_OUT), fix ? 16'h0 : 16'h1);
        if (fix) begin
            rand_requests();
            tick();
            check_eq({tag, "_fix_pc"},    pc_now(), tgt);
            check_eq({tag, "_fix_ready"}, 16'(bus.ready_OUT), 16'h1);
        end
        idle_inputs();
        m_pc = tgt;
    endtask

    task automatic load_pc(input logic [15:0] v);
        run_op("load", 1'b1, 1'b1, v[7:0], v[15:8], 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        check_reset_outputs("rst0");
        tick();
        tick();
        check_reset_outputs("rst1");
        rst = 1'b0;
        do_vector(8'h34, 8'h12);

        load_pc(16'h12FF);
        run_op("inc_carry", 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        load_pc(16'hFFFF);
        run_op("inc_wrap", 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        load_pc(16'h12F0);
        run_op("br_fwd_cross", 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20);
        load_pc(16'h12F0);
        run_op("br_fwd_same", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h05);
        load_pc(16'h1305);
        run_op("br_back_cross", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFA);
        run_op("br_zero", 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00);
        load_pc(16'h12FF);
        run_op("hi_load_inc", 1'b0, 1'b1, 8'h00, 8'h80, 1'b1, 1'b0, 8'h00);
        run_op("lo_load_br", 1'b1, 1'b0, 8'hF0, 8'h00, 1'b1, 1'b1, 8'h7F);

        for (int i = 0; i < 300; i++) begin
            logic       lo_en, hi_en, inc, br;
            logic [7:0] off;
            lo_en = ($urandom_range(0, 5) == 0);
            hi_en = ($urandom_range(0, 5) == 0);
            inc   = 1'($urandom);
            br    = ($urandom_range(0, 2) == 0);
            off   = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            run_op("rand", lo_en, hi_en, 8'($urandom), 8'($urandom), inc, br, off);
        end

        // Reset in the middle of a fix-up cycle aborts it and restarts the vector fetch.
        load_pc(16'h12F0);
        bus.branch_EN       = 1'b1;
        bus.branchOffset_IN = 8'h20;
        tick();
        idle_inputs();
        check_eq("pre_abort_ready", 16'(bus.ready_OUT), 16'h0);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort_fix");
        tick();
        check_reset_outputs("abort_hold");
        rst = 1'b0;
        do_vector(8'hCD, 8'hAB);

        // Reset in the middle of the vector fetch.
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_run");
        rst = 1'b0;
        bus.dataBus_IN = 8'h11;
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("abort_vec");
        tick();
        rst = 1'b0;
        do_vector(8'h00, 8'h80);
        run_op("post_vec_inc", 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_inc_reg.md
PC_INC_REG -- requirements
Module: pc_inc_reg

Interface
REQ-001 The block SHALL have exactly one clock domain and SHALL use an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 addressLow_EN  input  1  in RUN, load PCL from addressLowBus_IN.
REQ-005 addressHigh_EN  input  1  in RUN, load PCH from addressHighBus_IN.
REQ-006 addressLowBus_IN  input  8  address low bus value.
REQ-007 addressHighBus_IN  input  8  address high bus value.
REQ-008 inc_EN  input  1  increment the 16-bit PC by 1.
REQ-009 branch_EN  input  1  add branchOffset_IN to the PC.
REQ-010 branchOffset_IN  input  8  two's-complement relative offset.
REQ-011 dataBus_IN  input  8  data bus, sampled during the vector fetch.
REQ-012 addressLow_OUT  output  8  address low driven to the memory bus.
REQ-013 addressHigh_OUT  output  8  address high driven to the memory bus.
REQ-014 pcLow_OUT  output  8  current PCL register.
REQ-015 pcHigh_OUT  output  8  current PCH register.
REQ-016 ready_OUT  output  1  high only in RUN, meaning requests are accepted.
REQ-017 vectorActive_OUT  output  1  high in VEC_LO and VEC_HI.

Function
REQ-018 The FSM SHALL have exactly four states: VEC_LO, VEC_HI, RUN and FIXUP.
REQ-019 VEC_LO: addressHigh_OUT/addressLow_OUT = 8'hFF/8'hFC; at the clock edge PCL <= dataBus_IN; next state VEC_HI.
REQ-020 VEC_HI: address = 8'hFF/8'hFD; at the clock edge PCH <= dataBus_IN; next state RUN.
REQ-021 In RUN and FIXUP, addressHigh_OUT/addressLow_OUT SHALL equal PCH/PCL combinationally.
REQ-022 In VEC_LO and VEC_HI, all request inputs SHALL be ignored.
REQ-023 RUN, selection step: selLo = addressLow_EN ? addressLowBus_IN : PCL; selHi = addressHigh_EN ? addressHighBus_IN : PCH; low and high are selected independently.
REQ-024 RUN with inc_EN=1 and branch_EN=0: {PCH,PCL} <= {selHi,selLo}+1 (mod 2^16), with the carry from low to high; 16'hFFFF SHALL wrap to 16'h0000; state stays RUN.
REQ-025 RUN with inc_EN=0 and branch_EN=0: {PCH,PCL} <= {selHi,selLo}.
REQ-026 RUN with branch_EN=1 and neither load enable asserted: sum = PCL + sign-extended offset (9-bit); PCL <= sum[7:0]; inc_EN is ignored.
REQ-027 For a branch, a page cross SHALL occur when the offset is non-negative and carry=1 (direction +1), or the offset is negative and there is no carry (direction -1).
REQ-028 On a branch page cross: the direction is latched, PCH is unchanged this cycle, and the next state is FIXUP; with no page cross the state stays RUN.
REQ-029 RUN with branch_EN=1 and any load enable asserted: the load wins, and REQ-024/025 apply with inc_EN treated as 0.
REQ-030 FIXUP: PCH <= PCH +/- 1 (mod 256) per the latched direction; PCL held; all requests ignored; ready_OUT=0; next state RUN.
REQ-031 A zero branch offset SHALL leave the PC unchanged and cause no FIXUP.

Reset
REQ-032 While rst=1 (asynchronous): state=VEC_LO, PCL=PCH=8'h00, latched direction=+1.
REQ-033 While rst=1, outputs SHALL be: addressHigh_OUT/addressLow_OUT=FF/FC, pcHigh_OUT/pcLow_OUT=00/00, ready_OUT=0, vectorActive_OUT=1.
REQ-034 Reset asserted in any state, including mid-FIXUP or mid-vector, SHALL abort the operation and restart the vector fetch after release.
REQ-035 The first clock edge after rst deasserts SHALL be the VEC_LO capture edge.

Verification
REQ-036 Release rst; dataBus_IN=34 then 12 -> address FFFC then FFFD; PC=1234; ready_OUT=1 on the third cycle.
REQ-037 PC=12FF, inc_EN -> PC=1300; PC=FFFF, inc_EN -> PC=0000.
REQ-038 PC=12F0, branch_EN with offset 20 -> PCL=10 with ready_OUT=0 for one cycle, then PC=1310; offset 05 -> PC=12F5 with no FIXUP.
REQ-039 PC=1305, offset FA -> PCL=FF, FIXUP, PC=12FF.
REQ-040 addressHigh_EN=1 (bus 80) with inc_EN and PC=12FF -> PC=8100; addressLow_EN and branch_EN together -> load wins, no FIXUP.
REQ-041 Assert rst during FIXUP -> immediate FFFC on the address bus, PC=0000, and the vector fetch repeats.
